// File: rtl/bus_ctrl.sv
// bus_ctrl -- board-level bus cycle controller between the CPU core pins and
// memory / I/O devices.
//
// Converts the core strobes (rd/wr active-low, mem_io select) into a timed
// device cycle IDLE -> SETUP -> ACCESS -> HOLD -> DONE. It inserts programmable
// wait states (MEM_WS / IO_WS), extends I/O cycles until io_ready, and aborts
// I/O cycles after IO_TIMEOUT ACCESS cycles. It stalls the core through
// pin_wait and flags timeouts and rd+wr together on bus_error.
//
// Ports:
//   clk, arst        clock, synchronous active-low reset
//   address_bus      22-bit address from the core
//   data_bus_out     write data from the core
//   rd, wr           active-low read / write strobes from the core
//   mem_io           1 = memory, 0 = I/O
//   data_bus_in      registered read data returned to the core
//   pin_wait         1 stalls the core (SETUP and ACCESS)
//   dev_addr/wdata   address / write data latched for the devices
//   dev_rdata        read data from the devices
//   mem_*_n, io_*_n  active-low device strobes
//   io_ready         I/O device completion (ignored for memory)
//   bus_error        one-cycle pulse on I/O timeout or illegal strobes
module bus_ctrl #(
  parameter int MEM_WS     = 1,
  parameter int IO_WS      = 3,
  parameter int IO_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [21:0] address_bus,
  input  logic [7:0]  data_bus_out,
  input  logic        rd,
  input  logic        wr,
  input  logic        mem_io,
  output logic [7:0]  data_bus_in,
  output logic        pin_wait,
  output logic [21:0] dev_addr,
  output logic [7:0]  dev_wdata,
  input  logic [7:0]  dev_rdata,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        io_ce_n,
  output logic        io_oe_n,
  output logic        io_we_n,
  input  logic        io_ready,
  output logic        bus_error
);

  localparam logic [3:0] MEM_WS_C  = 4'(MEM_WS);
  localparam logic [3:0] IO_WS_C   = 4'(IO_WS);
  // Timeout fires on the edge that ends the IO_TIMEOUT-th ACCESS cycle.
  localparam logic [7:0] TO_LAST_C = 8'(IO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ws_cnt, ws_cnt_nxt;
  logic [7:0]  to_cnt, to_cnt_nxt;
  logic [7:0]  dbi_nxt;
  logic        err_nxt;
  logic        latch_req;
  logic        sel_mem;
  logic        is_read;

  logic        rd_req, wr_req, both_req;
  logic        ws_done, ready_ok, timed_out;

  assign rd_req    = !rd && wr;
  assign wr_req    = rd && !wr;
  assign both_req  = !rd && !wr;
  assign ws_done   = (ws_cnt == 4'd0);
  // Memory never waits on io_ready.
  assign ready_ok  = sel_mem || io_ready;
  assign timed_out = !sel_mem && (to_cnt == TO_LAST_C);

  always_comb begin
    state_nxt  = state;
    ws_cnt_nxt = ws_cnt;
    to_cnt_nxt = to_cnt;
    dbi_nxt    = data_bus_in;
    err_nxt    = 1'b0;
    latch_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (both_req) begin
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else if (rd_req || wr_req) begin
          latch_req = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        ws_cnt_nxt = sel_mem ? MEM_WS_C : IO_WS_C;
        to_cnt_nxt = 8'd0;
        state_nxt  = S_ACCESS;
      end
      S_ACCESS: begin
        // Normal completion wins over a timeout landing on the same edge.
        if (ws_done && ready_ok) begin
          state_nxt = S_HOLD;
          if (is_read) dbi_nxt = dev_rdata;
        end else if (timed_out) begin
          state_nxt = S_HOLD;
          err_nxt   = 1'b1;
          if (is_read) dbi_nxt = 8'hFF;
        end else begin
          if (!ws_done) ws_cnt_nxt = ws_cnt - 4'd1;
          if (!sel_mem) to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        // One device cycle per strobe assertion: wait for full release.
        if (rd && wr) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      state       <= S_IDLE;
      ws_cnt      <= 4'd0;
      to_cnt      <= 8'd0;
      data_bus_in <= 8'd0;
      bus_error   <= 1'b0;
      dev_addr    <= 22'd0;
      dev_wdata   <= 8'd0;
      sel_mem     <= 1'b0;
      is_read     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ws_cnt      <= ws_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      data_bus_in <= dbi_nxt;
      bus_error   <= err_nxt;
      if (latch_req) begin
        dev_addr  <= address_bus;
        dev_wdata <= data_bus_out;
        sel_mem   <= mem_io;
        is_read   <= !rd;
      end
    end
  end

  // Strobes decode from registered state and latched selects only.
  logic active, in_access;
  assign active    = (state == S_SETUP) || (state == S_ACCESS) || (state == S_HOLD);
  assign in_access = (state == S_ACCESS);

  assign pin_wait = (state == S_SETUP) || (state == S_ACCESS);
  assign mem_ce_n = !(active && sel_mem);
  assign io_ce_n  = !(active && !sel_mem);
  assign mem_oe_n = !(in_access && sel_mem && is_read);
  assign mem_we_n = !(in_access && sel_mem && !is_read);
  assign io_oe_n  = !(in_access && !sel_mem && is_read);
  assign io_we_n  = !(in_access && !sel_mem && !is_read);

endmodule

// File: tb/tb_bus_ctrl.sv
// Testbench for bus_ctrl: directed scenarios plus randomized transactions,
// checked against a per-transaction timing/data model.
module tb_bus_ctrl;
  localparam int MEM_WS     = 1;
  localparam int IO_WS      = 3;
  localparam int IO_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic [21:0] address_bus = '0;
  logic [7:0]  data_bus_out = '0;
  logic        rd = 1'b1;
  logic        wr = 1'b1;
  logic        mem_io = 1'b1;
  logic [7:0]  data_bus_in;
  logic        pin_wait;
  logic [21:0] dev_addr;
  logic [7:0]  dev_wdata;
  logic [7:0]  dev_rdata = '0;
  logic        mem_ce_n, mem_oe_n, mem_we_n;
  logic        io_ce_n, io_oe_n, io_we_n;
  logic        io_ready = 1'b0;
  logic        bus_error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_dbi = 8'h00;

  always #5 clk = ~clk;

  bus_ctrl #(.MEM_WS(MEM_WS), .IO_WS(IO_WS), .IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clk(clk), .arst(arst), .address_bus(address_bus), .data_bus_out(data_bus_out),
    .rd(rd), .wr(wr), .mem_io(mem_io), .data_bus_in(data_bus_in), .pin_wait(pin_wait),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .io_ce_n(io_ce_n), .io_oe_n(io_oe_n), .io_we_n(io_we_n),
    .io_ready(io_ready), .bus_error(bus_error)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete core access. ready_at: ACCESS cycle index (0-based) in which
  // io_ready goes high, -1 for never. jitter scrambles address/mem_io while busy.
  task automatic run_access(input bit is_mem, input bit is_rd, input logic [21:0] addr,
                            input logic [7:0] wd, input logic [7:0] rdv,
                            input int ready_at, input bit jitter, input string tag);
    int acc_exp, pw_exp, err_exp, r;
    bit tmo, hold_seen, wrong_now;
    logic [7:0] new_dbi;
    logic ce_sel, acc_sel;
    int n_pw, n_acc, n_wrong, n_err, n_lat_bad;

    // Reference: cycle counts from the wait-state / ready / timeout rules.
    if (is_mem) begin
      acc_exp = MEM_WS + 1;
      tmo = 1'b0;
    end else begin
      r = (ready_at < 0) ? 1000000 : ready_at + 1;
      acc_exp = (IO_WS + 1 > r) ? IO_WS + 1 : r;
      tmo = (acc_exp > IO_TIMEOUT);
      if (tmo) acc_exp = IO_TIMEOUT;
    end
    pw_exp  = acc_exp + 1;
    err_exp = tmo ? 1 : 0;
    new_dbi = is_rd ? (tmo ? 8'hFF : rdv) : exp_dbi;

    n_pw = 0; n_acc = 0; n_wrong = 0; n_err = 0; n_lat_bad = 0; hold_seen = 1'b0;
    ce_sel = 1'b1; acc_sel = 1'b1;

    @(negedge clk);
    address_bus  = addr;
    data_bus_out = wd;
    mem_io       = is_mem;
    rd           = !is_rd;
    wr           = is_rd;
    dev_rdata    = rdv;
    io_ready     = 1'b0;

    for (int k = 0; k < 300 && !hold_seen; k++) begin
      @(negedge clk);
      n_err += int'(bus_error);
      ce_sel  = is_mem ? mem_ce_n : io_ce_n;
      acc_sel = is_rd ? (is_mem ? mem_oe_n : io_oe_n) : (is_mem ? mem_we_n : io_we_n);
      wrong_now = (is_mem ? (!io_ce_n || !io_oe_n || !io_we_n)
                          : (!mem_ce_n || !mem_oe_n || !mem_we_n))
               || (is_rd ? !(is_mem ? mem_we_n : io_we_n) : !(is_mem ? mem_oe_n : io_oe_n))
               || (!pin_wait && !acc_sel);
      if (wrong_now) n_wrong++;
      if (pin_wait) begin
        n_pw++;
        if (!acc_sel) n_acc++;
        if (!ce_sel && (dev_addr !== addr || (!is_rd && dev_wdata !== wd))) n_lat_bad++;
        io_ready = (ready_at >= 0) && (n_acc - 1 >= ready_at);
        if (jitter) begin
          address_bus = 22'($urandom);
          mem_io      = 1'($urandom);
        end
      end else if (n_pw > 0) begin
        hold_seen = 1'b1;
      end
    end

    if (!hold_seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s completion: no HOLD seen within 300 cycles (pin_wait cycles %0d)", tag, n_pw);
    end else begin
      n_cmp++;
      if (n_pw !== pw_exp) begin
        n_bad++; $display("FAIL %s pin_wait_cycles: got %0d expected %0d", tag, n_pw, pw_exp);
      end
      n_cmp++;
      if (n_acc !== acc_exp) begin
        n_bad++; $display("FAIL %s access_cycles: got %0d expected %0d", tag, n_acc, acc_exp);
      end
      n_cmp++;
      if (data_bus_in !== new_dbi) begin
        n_bad++; $display("FAIL %s hold_data: got %h expected %h", tag, data_bus_in, new_dbi);
      end
      n_cmp++;
      if ({ce_sel, acc_sel} !== 2'b01) begin
        n_bad++; $display("FAIL %s hold_strobes: ce/access got %b expected 01", tag, {ce_sel, acc_sel});
      end
      n_cmp++;
      if (dev_addr !== addr) begin
        n_bad++; $display("FAIL %s hold_addr: got %h expected %h", tag, dev_addr, addr);
      end
    end

    // Release the strobes; FSM passes DONE then IDLE.
    rd = 1'b1; wr = 1'b1; io_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_err += int'(bus_error);
      if ({mem_ce_n, mem_oe_n, mem_we_n, io_ce_n, io_oe_n, io_we_n, pin_wait} !== 7'b1111110)
        n_wrong++;
    end

    n_cmp++;
    if (n_err !== err_exp) begin
      n_bad++; $display("FAIL %s bus_error_pulses: got %0d expected %0d", tag, n_err, err_exp);
    end
    n_cmp++;
    if (n_wrong !== 0) begin
      n_bad++; $display("FAIL %s stray_strobes: got %0d bad cycles expected 0", tag, n_wrong);
    end
    n_cmp++;
    if (n_lat_bad !== 0) begin
      n_bad++; $display("FAIL %s latched_addr_data: got %0d bad cycles expected 0", tag, n_lat_bad);
    end
    n_cmp++;
    if (data_bus_in !== new_dbi) begin
      n_bad++; $display("FAIL %s held_data: got %h expected %h", tag, data_bus_in, new_dbi);
    end
    exp_dbi = new_dbi;
  endtask

  task automatic test_reset();
    arst = 1'b0; rd = 1'b1; wr = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, io_ce_n, io_oe_n, io_we_n, pin_wait, bus_error} !== 8'b11111100) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 11111100",
               {mem_ce_n, mem_oe_n, mem_we_n, io_ce_n, io_oe_n, io_we_n, pin_wait, bus_error});
    end
    n_cmp++;
    if ({data_bus_in, dev_addr, dev_wdata} !== 38'd0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h/%h expected zeros", data_bus_in, dev_addr, dev_wdata);
    end
    exp_dbi = 8'h00;
    arst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mem_read();
    run_access(1'b1, 1'b1, 22'h01_2345, 8'h00, 8'h5A, -1, 1'b0, "mem_read");
  endtask

  task automatic test_mem_write();
    run_access(1'b1, 1'b0, 22'h3F_0012, 8'hC3, 8'h11, -1, 1'b0, "mem_write");
  endtask

  task automatic test_io_ready();
    run_access(1'b0, 1'b1, 22'h00_0040, 8'h00, 8'h96, 7, 1'b0, "io_ready_late");
    run_access(1'b0, 1'b1, 22'h00_0041, 8'h00, 8'h3C, 0, 1'b0, "io_ready_early");
    run_access(1'b0, 1'b0, 22'h00_0042, 8'h77, 8'h00, 5, 1'b0, "io_write");
    run_access(1'b0, 1'b1, 22'h00_0043, 8'h00, 8'hA5, IO_TIMEOUT - 1, 1'b0, "io_ready_at_limit");
  endtask

  task automatic test_io_timeout();
    run_access(1'b0, 1'b1, 22'h00_0080, 8'h00, 8'h12, -1, 1'b0, "io_timeout");
  endtask

  task automatic test_illegal();
    int n_ce, n_pw, n_err;
    n_ce = 0; n_pw = 0; n_err = 0;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; mem_io = 1'($urandom);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_err += int'(bus_error);
      if (!mem_ce_n || !io_ce_n) n_ce++;
      if (pin_wait) n_pw++;
    end
    // Partial release must not start a new cycle while still in DONE.
    wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_err += int'(bus_error);
      if (!mem_ce_n || !io_ce_n) n_ce++;
      if (pin_wait) n_pw++;
    end
    rd = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (n_err !== 1) begin
      n_bad++; $display("FAIL illegal_bus_error: got %0d pulses expected 1", n_err);
    end
    n_cmp++;
    if (n_ce !== 0 || n_pw !== 0) begin
      n_bad++; $display("FAIL illegal_no_cycle: got ce %0d / wait %0d cycles expected 0/0", n_ce, n_pw);
    end
    n_cmp++;
    if (data_bus_in !== exp_dbi) begin
      n_bad++; $display("FAIL illegal_data_held: got %h expected %h", data_bus_in, exp_dbi);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    address_bus = 22'h00_0123; mem_io = 1'b0; rd = 1'b0; wr = 1'b1;
    dev_rdata = 8'h44; io_ready = 1'b0;
    repeat (6) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, io_ce_n, io_oe_n, io_we_n, pin_wait, bus_error} !== 8'b11111100) begin
      n_bad++;
      $display("FAIL midreset_ctrl: got %b expected 11111100",
               {mem_ce_n, mem_oe_n, mem_we_n, io_ce_n, io_oe_n, io_we_n, pin_wait, bus_error});
    end
    n_cmp++;
    if (data_bus_in !== 8'h00) begin
      n_bad++; $display("FAIL midreset_data: got %h expected 00", data_bus_in);
    end
    exp_dbi = 8'h00;
    arst = 1'b1; rd = 1'b1;
    @(negedge clk);
    run_access(1'b1, 1'b1, 22'h2A_AAAA, 8'h00, 8'hE7, -1, 1'b0, "post_reset_read");
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 22'h10_0001, 8'h01, 8'h00, -1, 1'b0, "b2b_0");
    run_access(1'b1, 1'b1, 22'h10_0002, 8'h00, 8'hB4, -1, 1'b0, "b2b_1");
    run_access(1'b0, 1'b1, 22'h10_0003, 8'h00, 8'h69, 2, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    int sel, ready_at;
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      ready_at = -1;
      else if (sel == 1) ready_at = int'($urandom_range(60, 70));
      else               ready_at = int'($urandom_range(0, 10));
      run_access(1'($urandom), 1'($urandom), 22'($urandom), 8'($urandom), 8'($urandom),
                 ready_at, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io_ready();
    test_io_timeout();
    test_illegal();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Board-level bus cycle controller directly downstream of the CPU core's external pins. It turns the core's `address_bus`/`rd`/`wr`/`mem_io`/`data_bus_out` strobes into timed memory or I/O device cycles with programmable wait states and I/O ready extension. It returns read data on `data_bus_in` and stalls the core through `pin_wait` until each access completes. It also detects I/O timeouts and illegal strobe combinations.

## Interface
- `MEM_WS`, 1: extra ACCESS cycles for memory, 0..15.
- `IO_WS`, 3: minimum extra ACCESS cycles for I/O, 0..15.
- `IO_TIMEOUT`, 64: maximum ACCESS cycles an I/O access may wait for `io_ready`, 1..255.
- `clk` in 1: single clock; every register updates on its rising edge.
- `arst` in 1: reset, synchronous, active-low.
- `address_bus` in 22: address from the core.
- `data_bus_out` in 8: write data from the core.
- `rd` in 1: read strobe, active-low.
- `wr` in 1: write strobe, active-low.
- `mem_io` in 1: 1 selects memory, 0 selects I/O.
- `data_bus_in` out 8: read data to the core, registered.
- `pin_wait` out 1: 1 stalls the core.
- `dev_addr` out 22: latched address to devices.
- `dev_wdata` out 8: latched write data to devices.
- `dev_rdata` in 8: read data from devices.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n` out 1 each: memory strobes.
- `io_ce_n`, `io_oe_n`, `io_we_n` out 1 each: I/O strobes.
- `io_ready` in 1: I/O device completion; ignored for memory.
- `bus_error` out 1: one-cycle pulse on timeout or illegal strobes.

## Operation
- **States:** IDLE, SETUP, ACCESS, HOLD, DONE.
- **IDLE:**
  - `rd`=0 xor `wr`=0 goes to SETUP. On that edge it latches `dev_addr`, `dev_wdata`, direction and `mem_io`.
  - `rd`=0 and `wr`=0 together is illegal: no device cycle, `bus_error` pulses, go to DONE.
- **SETUP:** lasts one cycle. The selected `*_ce_n` is 0 and `pin_wait`=1. Next state is ACCESS, and the counter loads `MEM_WS` or `IO_WS`.
- **ACCESS:**
  - Holds `*_ce_n`=0 and `*_oe_n`=0 (read) or `*_we_n`=0 (write), with `pin_wait`=1.
  - The counter decrements to 0.
  - The exit condition is counter==0, plus `io_ready`=1 for I/O.
  - On exit, a read captures `dev_rdata` into `data_bus_in`, and the next state is HOLD.
- **I/O timeout:** a separate timeout counter counts ACCESS cycles for I/O. When it reaches `IO_TIMEOUT` without ready, the access terminates: go to HOLD, `data_bus_in`=8'hFF, `bus_error` pulses.
- **HOLD:** lasts one cycle. oe/we are 1, ce stays 0, `pin_wait`=0.
- **DONE:**
  - All device strobes are 1 and `pin_wait`=0.
  - Stays in DONE until `rd`=1 and `wr`=1, then goes to IDLE. This gives exactly one device cycle per core strobe assertion.
- **Held outputs:** `data_bus_in` holds its value until the next read completes. Writes never change it.
- **Mode/address changes mid-access:** changes to `mem_io` or address after SETUP entry are ignored, because the latched values are used.
- **Reset (`arst`=0 at an edge):**
  - Next state is IDLE.
  - All `*_ce_n`, `*_oe_n`, `*_we_n` are 1; `pin_wait`=0; `bus_error`=0.
  - `data_bus_in`, `dev_addr`, `dev_wdata` are 0; counters are 0.
  - Reset mid-access aborts the cycle with no capture.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- **Memory read, MEM_WS=n:** strobe sampled at edge E0; SETUP from E0, ACCESS for n+1 cycles, HOLD, DONE.
  - `pin_wait` is high for n+2 cycles.
  - Data is valid on `data_bus_in` from the start of HOLD, which is E0+n+2 edges.
- **Write:** same cycle count. `we_n` is low only during ACCESS, and `dev_wdata` is stable from SETUP through HOLD.
- **I/O:** ACCESS lasts max(`IO_WS`+1, ready-arrival) cycles, capped at `IO_TIMEOUT`.
- **Back-to-back:** the minimum gap between the completion of one access and the acceptance of the next is one IDLE cycle after strobe release.

## Test plan
- **Memory read, MEM_WS=1, `dev_rdata`=8'h5A, `rd` low:** `pin_wait` high for exactly 3 cycles, `mem_oe_n` low for 2 cycles, `data_bus_in`=8'h5A from HOLD onward, `io_*` stays 1.
- **Memory write to 22'h3F_0012 with 8'hC3:** `mem_we_n` low for 2 cycles with `dev_addr`=22'h3F_0012 and `dev_wdata`=8'hC3. `data_bus_in` is unchanged.
- **I/O read, IO_WS=3, `io_ready` rising 7 cycles into ACCESS:** ACCESS lasts 8 cycles and `data_bus_in`=`dev_rdata`. No `bus_error`.
- **I/O read, `io_ready` stuck 0, IO_TIMEOUT=64:** terminates after 64 ACCESS cycles, `data_bus_in`=8'hFF, one-cycle `bus_error`, `pin_wait` drops.
- **`rd`=0 and `wr`=0 in IDLE:** no ce asserted, `bus_error` pulses once. The FSM stays in DONE until both strobes are released.
- **`arst`=0 during I/O ACCESS:** next cycle all strobes are 1, `pin_wait`=0, `data_bus_in`=0. A new read after reset completes normally.
